exec_stage_hs: RTL and testbench
================================

# exec_stage_hs

Parametrised execute stage for the in-order core. Replaces the fixed-phase execute step with a valid/ready pipeline stage. Computes ALU results, branch decisions and targets, and memory addresses, then holds them in an output register until the memory stage accepts them. An optional iterative multiply/divide unit adds multi-cycle operations that stall the upstream stage.

## Interface
Parameters:
- XLEN, 32: datapath width; must be a power of two, at least 8.
- REG_AW, 5: register-index width.
- PC_STEP, 4: link increment used for unconditional branches.

Ports:
- clk  in  1  clock.
- rst  in  1  reset; synchronous, active-high.
- flush  in  1  discard the held output and abort any in-flight multiply/divide.
- in_valid  in  1  upstream holds an instruction.
- in_ready  out  1  stage accepts the instruction this cycle.
- in_pc, in_imm, in_rs1_data, in_rs2_data  in  XLEN each  operands.
- in_alu_ctl  in  4  operation code (exec_pkg encoding).
- in_branch_uc, in_branch_c, in_branch_relative, in_alu_src, in_mem_read, in_mem_write, in_reg_write  in  1 each  decode controls.
- in_rd  in  REG_AW  destination register.
- out_valid  out  1  output register holds a result.
- out_ready  in  1  downstream accepts the result.
- out_mem_read, out_mem_write, out_reg_write, out_branch  out  1 each  registered controls and branch decision.
- out_rd  out  REG_AW  destination register.
- out_branch_addr, out_mem_addr, out_mem_write_data, out_result  out  XLEN each  registered results.

## Operation
- Operand select: op2 = in_alu_src ? in_imm : in_rs2_data.
- Single-cycle ops:
  - 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR.
  - 5 SLL, 6 SRL, 7 SRA; shift amount is op2[$clog2(XLEN)-1:0].
  - 8 SLT, 9 SLTU; result is 1 or 0, zero-extended.
- Multi-cycle ops (only with EXEC_MULDIV_EN):
  - 10 MUL: low XLEN bits of the product.
  - 11 MULH: signed×signed, high XLEN bits.
  - 12 DIV, 13 DIVU, 14 REM, 15 REMU.
- Divide by zero: quotient is all ones; remainder equals the dividend.
- Signed overflow (most negative value ÷ −1): quotient equals the dividend; remainder is 0.
- Branch decision: out_branch = in_branch_uc | (in_branch_c & (alu != 0)).
- Branch target:
  - If in_branch_relative: in_pc + alu when in_branch_uc, otherwise in_pc + in_imm.
  - Otherwise: alu.
  - All additions are modulo 2^XLEN.
- out_result = in_branch_uc ? in_pc + PC_STEP : alu.
- out_mem_addr = alu.
- out_mem_write_data = in_rs2_data.
- All control bits and in_rd are registered alongside the result.
- in_ready = (state == IDLE) & (!out_valid | out_ready).
- Accept condition: in_valid & in_ready.
- FSM states:
  - IDLE: on accept of a single-cycle op, load the output register. On accept of a muldiv op, latch operands and opcode, set the counter to XLEN−1, and go to BUSY.
  - BUSY: one quotient or partial-product bit per cycle; the counter decrements. When the counter reaches 0, go to DONE.
  - DONE: load the output register when !out_valid | out_ready, then go to IDLE; otherwise stay in DONE.
- Output register: out_valid sets on load. It clears on out_valid & out_ready when no new load happens in the same cycle. A simultaneous load and drain keeps out_valid at 1 and replaces the contents.
- flush: out_valid is forced to 0 and the FSM returns to IDLE. An instruction presented in the same cycle is not accepted, because in_ready is forced to 0 while flush is high.

## Timing
- Reset: out_valid=0, state=IDLE, and every output data/control register is 0. in_ready=1 in the first cycle after reset.
- Single-cycle op accepted at edge N: out_valid=1 after edge N. Back-to-back throughput is one per cycle while out_ready=1.
- Muldiv op accepted at edge N: BUSY from N through N+XLEN−1, DONE at N+XLEN, out_valid=1 after edge N+XLEN+1 when unblocked. Latency is XLEN+1 cycles.
- in_ready stays 0 throughout BUSY and DONE.
- Backpressure: while out_valid=1 and out_ready=0, all out_* outputs are held stable.
- rst or flush in the middle of BUSY discards the operation; no output is produced.

## Configuration
- EXEC_MULDIV_EN defined: the exec_muldiv instance and the BUSY/DONE states are compiled in.
- EXEC_MULDIV_EN undefined:
  - Opcodes 10–15 complete as single-cycle ops with alu = 0.
  - The FSM reduces to IDLE only.
  - in_ready = !out_valid | out_ready.

## Structure
- Package exec_pkg holds:
  - The 4-bit alu_ctl_t enum (codes above).
  - The muldiv state enum.
  - A helper function is_muldiv(op), returning op >= 10.
- Sub-module exec_muldiv, parameter XLEN:
  - Radix-2 restoring divider and shift-add multiplier sharing one accumulator.
  - Ports: start, op, a, b, busy, done, result.
  - The ALU combinational logic stays in exec_stage_hs.

## Test plan
- After reset: ADD rs1=5, rs2=7, alu_src=0, out_ready=1 → out_valid one cycle later, out_result=12, out_mem_addr=12.
- Conditional branch: branch_c=1, SUB rs1=3, rs2=4, relative=1, pc=0x100, imm=0x20 → out_branch=1, branch_addr=0x120. Same with rs2=3 → out_branch=0.
- Unconditional branch: branch_uc=1, relative=1, ADD rs1=0, imm=8, pc=0x40 → branch_addr=0x48, out_result=0x44.
- Backpressure: out_ready=0 for 3 cycles with in_valid=1 → in_ready=0, outputs stable; the first instruction drains and the next one is accepted in the same cycle that out_ready rises.
- Divide and multiply (EXEC_MULDIV_EN):
  - DIV 0x80000000 / 0xFFFFFFFF → 0x80000000.
  - DIVU 7/0 → 0xFFFFFFFF.
  - REMU 7/0 → 7.
  - MUL 6×7 → 42, with out_valid exactly 33 cycles after accept.
- Flush two cycles into BUSY → no out_valid, in_ready=1 the next cycle, and a following ADD completes normally.

Source files
------------

// File: rtl/exec_pkg.sv
// Shared types for the execute stage: ALU opcode encoding, multiply/divide FSM states
// and the opcode classifier.
package exec_pkg;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_AND  = 4'd2,
        ALU_OR   = 4'd3,
        ALU_XOR  = 4'd4,
        ALU_SLL  = 4'd5,
        ALU_SRL  = 4'd6,
        ALU_SRA  = 4'd7,
        ALU_SLT  = 4'd8,
        ALU_SLTU = 4'd9,
        ALU_MUL  = 4'd10,
        ALU_MULH = 4'd11,
        ALU_DIV  = 4'd12,
        ALU_DIVU = 4'd13,
        ALU_REM  = 4'd14,
        ALU_REMU = 4'd15
    } alu_ctl_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } md_state_t;

    function automatic logic is_muldiv(input logic [3:0] op);
        return op >= 4'd10;
    endfunction

endpackage

// File: rtl/exec_stage_hs_if.sv
// Upstream (in_*) and downstream (out_*) handshake bundle of the execute stage.
// master drives instructions and out_ready; slave is the stage itself.
interface exec_stage_hs_if #(
    parameter int XLEN   = 32,
    parameter int REG_AW = 5
);
    logic              in_valid, in_ready;
    logic [XLEN-1:0]   in_pc, in_imm, in_rs1_data, in_rs2_data;
    logic [3:0]        in_alu_ctl;
    logic              in_branch_uc, in_branch_c, in_branch_relative, in_alu_src;
    logic              in_mem_read, in_mem_write, in_reg_write;
    logic [REG_AW-1:0] in_rd;

    logic              out_valid, out_ready;
    logic              out_mem_read, out_mem_write, out_reg_write, out_branch;
    logic [REG_AW-1:0] out_rd;
    logic [XLEN-1:0]   out_branch_addr, out_mem_addr, out_mem_write_data, out_result;

    modport master (
        output in_valid, in_pc, in_imm, in_rs1_data, in_rs2_data, in_alu_ctl,
               in_branch_uc, in_branch_c, in_branch_relative, in_alu_src,
               in_mem_read, in_mem_write, in_reg_write, in_rd, out_ready,
        input  in_ready, out_valid, out_mem_read, out_mem_write, out_reg_write,
               out_branch, out_rd, out_branch_addr, out_mem_addr, out_mem_write_data, out_result
    );

    modport slave (
        input  in_valid, in_pc, in_imm, in_rs1_data, in_rs2_data, in_alu_ctl,
               in_branch_uc, in_branch_c, in_branch_relative, in_alu_src,
               in_mem_read, in_mem_write, in_reg_write, in_rd, out_ready,
        output in_ready, out_valid, out_mem_read, out_mem_write, out_reg_write,
               out_branch, out_rd, out_branch_addr, out_mem_addr, out_mem_write_data, out_result
    );
endinterface

// File: rtl/exec_muldiv.sv
// Iterative multiply/divide: shift-add multiplier and radix-2 restoring divider sharing one
// accumulator, one bit per cycle. Only built when EXEC_MULDIV_EN is defined.
`ifdef EXEC_MULDIV_EN
module exec_muldiv
    import exec_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            kill,
    input  logic            start,
    input  alu_ctl_t        op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);
    localparam int CW = $clog2(XLEN);

    logic [2*XLEN-1:0] acc, prod;
    logic [XLEN-1:0]   opb, a_q, a_mag, b_mag, quo, rem;
    logic [CW-1:0]     cnt;
    alu_ctl_t          op_q;
    logic              neg_q, rem_neg_q, div0_q;
    logic              signed_op, a_neg, b_neg;
    logic [XLEN:0]     mul_sum, div_trial;
    logic [2*XLEN:0]   div_shift;

    // Signed ops run on magnitudes; the sign is reapplied to the finished result.
    assign signed_op = (op == ALU_MULH) || (op == ALU_DIV) || (op == ALU_REM);
    assign a_neg     = signed_op && a[XLEN-1];
    assign b_neg     = signed_op && b[XLEN-1];
    assign a_mag     = a_neg ? -a : a;
    assign b_mag     = b_neg ? -b : b;

    assign mul_sum   = {1'b0, acc[2*XLEN-1:XLEN]} + {1'b0, opb & {XLEN{acc[0]}}};
    assign div_shift = {acc, 1'b0};
    assign div_trial = div_shift[2*XLEN:XLEN] - {1'b0, opb};
    assign done      = busy && (cnt == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            busy      <= 1'b0;
            cnt       <= '0;
            op_q      <= ALU_ADD;
            a_q       <= '0;
            opb       <= '0;
            acc       <= '0;
            neg_q     <= 1'b0;
            rem_neg_q <= 1'b0;
            div0_q    <= 1'b0;
        end else if (kill) begin
            busy <= 1'b0;
        end else if (start) begin
            busy      <= 1'b1;
            cnt       <= CW'(XLEN - 1);
            op_q      <= op;
            a_q       <= a;
            opb       <= b_mag;
            acc       <= {{XLEN{1'b0}}, a_mag};
            neg_q     <= a_neg ^ b_neg;
            rem_neg_q <= a_neg;
            div0_q    <= (b == '0);
        end else if (busy) begin
            if (op_q >= ALU_DIV) begin
                if (!div_trial[XLEN])
                    acc <= {div_trial[XLEN-1:0], div_shift[XLEN-1:1], 1'b1};
                else
                    acc <= div_shift[2*XLEN-1:0];
            end else begin
                acc <= {mul_sum, acc[XLEN-1:1]};
            end
            cnt <= cnt - CW'(1);
            if (cnt == '0)
                busy <= 1'b0;
        end
    end

    always_comb begin
        prod = neg_q ? -acc : acc;
        quo  = div0_q ? '1 : (neg_q ? -acc[XLEN-1:0] : acc[XLEN-1:0]);
        rem  = div0_q ? a_q : (rem_neg_q ? -acc[2*XLEN-1:XLEN] : acc[2*XLEN-1:XLEN]);
        case (op_q)
            ALU_MUL:            result = prod[XLEN-1:0];
            ALU_MULH:           result = prod[2*XLEN-1:XLEN];
            ALU_DIV, ALU_DIVU:  result = quo;
            default:            result = rem;
        endcase
    end
endmodule
`endif

// File: rtl/exec_stage_hs.sv
// Valid/ready execute stage: ALU, branch decision/target, memory address, held output register.
// Define EXEC_MULDIV_EN to add multi-cycle multiply/divide (opcodes 10-15) via exec_muldiv.
module exec_stage_hs
    import exec_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int REG_AW  = 5,
    parameter int PC_STEP = 4
) (
    input logic            clk,
    input logic            rst,
    input logic            flush,
    exec_stage_hs_if.slave bus
);
    localparam int SHW = $clog2(XLEN);

    typedef struct packed {
        logic [XLEN-1:0]   pc;
        logic [XLEN-1:0]   imm;
        logic [XLEN-1:0]   rs2;
        logic              branch_uc, branch_c, branch_rel, mem_read, mem_write, reg_write;
        logic [REG_AW-1:0] rd;
    } fields_t;

    alu_ctl_t        ctl;
    fields_t         cur, src;
    logic [XLEN-1:0] op1, op2, alu, res, target_n, result_n;
    logic            accept, load, branch_n;

    assign ctl = alu_ctl_t'(bus.in_alu_ctl);
    assign op1 = bus.in_rs1_data;
    assign op2 = bus.in_alu_src ? bus.in_imm : bus.in_rs2_data;
    assign cur = '{pc: bus.in_pc, imm: bus.in_imm, rs2: bus.in_rs2_data,
                   branch_uc: bus.in_branch_uc, branch_c: bus.in_branch_c,
                   branch_rel: bus.in_branch_relative, mem_read: bus.in_mem_read,
                   mem_write: bus.in_mem_write, reg_write: bus.in_reg_write, rd: bus.in_rd};

    always_comb begin
        alu = '0;
        case (ctl)
            ALU_ADD:  alu = op1 + op2;
            ALU_SUB:  alu = op1 - op2;
            ALU_AND:  alu = op1 & op2;
            ALU_OR:   alu = op1 | op2;
            ALU_XOR:  alu = op1 ^ op2;
            ALU_SLL:  alu = op1 << op2[SHW-1:0];
            ALU_SRL:  alu = op1 >> op2[SHW-1:0];
            ALU_SRA:  alu = $signed(op1) >>> op2[SHW-1:0];
            ALU_SLT:  alu = {{(XLEN-1){1'b0}}, $signed(op1) < $signed(op2)};
            ALU_SLTU: alu = {{(XLEN-1){1'b0}}, op1 < op2};
            default:  alu = '0;
        endcase
    end

`ifdef EXEC_MULDIV_EN
    md_state_t       state;
    fields_t         pend;
    logic            md_start, md_busy, md_done, load_md;
    logic [XLEN-1:0] md_result;

    assign bus.in_ready = !flush && (state == ST_IDLE) && (!bus.out_valid || bus.out_ready);
    assign accept       = bus.in_valid && bus.in_ready;
    assign md_start     = accept && is_muldiv(bus.in_alu_ctl);
    assign load_md      = (state == ST_DONE) && (!bus.out_valid || bus.out_ready);
    assign load         = (accept && !md_start) || load_md;
    // A finished muldiv op completes with the controls captured when it was accepted.
    assign src          = (state == ST_DONE) ? pend : cur;
    assign res          = (state == ST_DONE) ? md_result : alu;

    exec_muldiv #(.XLEN(XLEN)) u_muldiv (
        .clk    (clk),
        .rst    (rst),
        .kill   (flush),
        .start  (md_start),
        .op     (ctl),
        .a      (op1),
        .b      (op2),
        .busy   (md_busy),
        .done   (md_done),
        .result (md_result)
    );
`else
    assign bus.in_ready = !flush && (!bus.out_valid || bus.out_ready);
    assign accept       = bus.in_valid && bus.in_ready;
    assign load         = accept;
    assign src          = cur;
    assign res          = alu;
`endif

    assign branch_n = src.branch_uc || (src.branch_c && (res != '0));
    assign target_n = src.branch_rel ? src.pc + (src.branch_uc ? res : src.imm) : res;
    assign result_n = src.branch_uc ? src.pc + XLEN'(PC_STEP) : res;

    always_ff @(posedge clk) begin
        if (rst) begin
            bus.out_valid          <= 1'b0;
            bus.out_branch         <= 1'b0;
            bus.out_mem_read       <= 1'b0;
            bus.out_mem_write      <= 1'b0;
            bus.out_reg_write      <= 1'b0;
            bus.out_rd             <= '0;
            bus.out_branch_addr    <= '0;
            bus.out_mem_addr       <= '0;
            bus.out_mem_write_data <= '0;
            bus.out_result         <= '0;
`ifdef EXEC_MULDIV_EN
            state <= ST_IDLE;
            pend  <= '0;
`endif
        end else if (flush) begin
            bus.out_valid <= 1'b0;
`ifdef EXEC_MULDIV_EN
            state <= ST_IDLE;
`endif
        end else begin
            if (load) begin
                bus.out_valid          <= 1'b1;
                bus.out_branch         <= branch_n;
                bus.out_mem_read       <= src.mem_read;
                bus.out_mem_write      <= src.mem_write;
                bus.out_reg_write      <= src.reg_write;
                bus.out_rd             <= src.rd;
                bus.out_branch_addr    <= target_n;
                bus.out_mem_addr       <= res;
                bus.out_mem_write_data <= src.rs2;
                bus.out_result         <= result_n;
            end else if (bus.out_valid && bus.out_ready) begin
                bus.out_valid <= 1'b0;
            end
`ifdef EXEC_MULDIV_EN
            case (state)
                ST_IDLE: if (md_start) begin
                    state <= ST_BUSY;
                    pend  <= cur;
                end
                ST_BUSY: if (md_done) state <= ST_DONE;
                         else if (!md_busy) state <= ST_IDLE;
                ST_DONE: if (load_md) state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
`endif
        end
    end
endmodule

// File: tb/tb_exec_stage_hs.sv
// Directed bench for exec_stage_hs with a scoreboard of expected output bundles.
// Multiply/divide steps are included when EXEC_MULDIV_EN is defined.
module tb_exec_stage_hs;
    logic clk = 1'b0;
    logic rst, flush;
    int   checks = 0, failures = 0;

    always #5 clk = ~clk;

    exec_stage_hs_if #(.XLEN(32), .REG_AW(5)) bus ();

    exec_stage_hs #(.XLEN(32), .REG_AW(5), .PC_STEP(4)) dut (
        .clk   (clk),
        .rst   (rst),
        .flush (flush),
        .bus   (bus)
    );

    typedef struct packed {
        logic        branch;
        logic [31:0] baddr, maddr, wdata, result;
        logic [4:0]  rd;
        logic        mr, mw, rw;
    } exp_t;

    exp_t sbq[$];

    function automatic exp_t model();
        logic [31:0] a, b, alu;
        logic [63:0] p;
        exp_t e;
        a = bus.in_rs1_data;
        b = bus.in_alu_src ? bus.in_imm : bus.in_rs2_data;
        p = '0;
        case (bus.in_alu_ctl)
            4'd0: alu = a + b;
            4'd1: alu = a - b;
            4'd2: alu = a & b;
            4'd3: alu = a | b;
            4'd4: alu = a ^ b;
            4'd5: alu = a << b[4:0];
            4'd6: alu = a >> b[4:0];
            4'd7: alu = $signed(a) >>> b[4:0];
            4'd8: alu = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'd9: alu = (a < b) ? 32'd1 : 32'd0;
`ifdef EXEC_MULDIV_EN
            4'd10: begin p = {32'd0, a} * {32'd0, b}; alu = p[31:0]; end
            4'd11: begin p = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b}); alu = p[63:32]; end
            4'd12: alu = (b == 0) ? 32'hFFFF_FFFF : (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) ? a
                         : $signed(a) / $signed(b);
            4'd13: alu = (b == 0) ? 32'hFFFF_FFFF : a / b;
            4'd14: alu = (b == 0) ? a : (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) ? 32'd0
                         : $signed(a) % $signed(b);
            4'd15: alu = (b == 0) ? a : a % b;
`endif
            default: alu = 32'd0;
        endcase
        e.branch = bus.in_branch_uc | (bus.in_branch_c & (alu != 0));
        e.baddr  = bus.in_branch_relative ? bus.in_pc + (bus.in_branch_uc ? alu : bus.in_imm) : alu;
        e.result = bus.in_branch_uc ? bus.in_pc + 32'd4 : alu;
        e.maddr  = alu;
        e.wdata  = bus.in_rs2_data;
        e.rd     = bus.in_rd;
        e.mr     = bus.in_mem_read;
        e.mw     = bus.in_mem_write;
        e.rw     = bus.in_reg_write;
        return e;
    endfunction

    // Pop-and-compare on every output transfer, push on every accepted instruction.
    always @(negedge clk) begin : monitor
        exp_t e, g;
        if (!rst) begin
            if (bus.out_valid && bus.out_ready) begin
                g = '{branch: bus.out_branch, baddr: bus.out_branch_addr, maddr: bus.out_mem_addr,
                      wdata: bus.out_mem_write_data, result: bus.out_result, rd: bus.out_rd,
                      mr: bus.out_mem_read, mw: bus.out_mem_write, rw: bus.out_reg_write};
                checks++;
                assert (sbq.size() != 0) else begin
                    failures++;
                    $error("FAIL sb_unexpected got=%h required=none", g);
                end
                if (sbq.size() != 0) begin
                    e = sbq.pop_front();
                    checks++;
                    assert (g === e) else begin
                        failures++;
                        $error("FAIL out_bundle got=%h required=%h", g, e);
                    end
                end
            end
            if (flush) sbq.delete();
            else if (bus.in_valid && bus.in_ready) sbq.push_back(model());
        end
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] expv);
        checks++;
        assert (got === expv) else begin
            failures++;
            $error("FAIL %s got=%0h required=%0h", tag, got, expv);
        end
    endtask

    task automatic set_op(input logic [3:0] ctl, input logic [31:0] rs1, input logic [31:0] rs2,
                          input logic [31:0] imm = 0, input logic [31:0] pc = 0,
                          input logic alu_src = 0, input logic uc = 0, input logic c = 0,
                          input logic rel = 0);
        bus.in_valid           = 1'b1;
        bus.in_alu_ctl         = ctl;
        bus.in_rs1_data        = rs1;
        bus.in_rs2_data        = rs2;
        bus.in_imm             = imm;
        bus.in_pc              = pc;
        bus.in_alu_src         = alu_src;
        bus.in_branch_uc       = uc;
        bus.in_branch_c        = c;
        bus.in_branch_relative = rel;
        bus.in_rd              = 5'($urandom_range(1, 31));
        bus.in_mem_read        = 1'($urandom_range(0, 1));
        bus.in_mem_write       = 1'($urandom_range(0, 1));
        bus.in_reg_write       = 1'($urandom_range(0, 1));
    endtask

    task automatic issue();
        int n = 0;
        @(negedge clk);
        while (!bus.in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("issue_in_ready", bus.in_ready, 1);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic stream(input logic [3:0] ctl, input logic [31:0] rs1, input logic [31:0] rs2,
                          input logic [31:0] imm, input logic alu_src);
        set_op(ctl, rs1, rs2, imm, 32'h200, alu_src);
        @(negedge clk);
        chk("stream_in_ready", bus.in_ready, 1);
        @(posedge clk); #1;
    endtask

    task automatic drain();
        int n = 0;
        while ((sbq.size() != 0 || bus.out_valid) && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("drain_queue_empty", sbq.size(), 0);
        @(posedge clk); #1;
    endtask

`ifdef EXEC_MULDIV_EN
    task automatic md_run(input logic [3:0] ctl, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] expv, input string tag, output int lat);
        set_op(ctl, a, b);
        issue();
        lat = 0;
        @(negedge clk);
        while (!bus.out_valid && lat < 100) begin
            if (lat == 5) chk({tag, "_busy_in_ready"}, bus.in_ready, 0);
            @(negedge clk);
            lat++;
        end
        chk(tag, bus.out_result, expv);
        @(posedge clk); #1;
    endtask
`endif

    initial begin
        #500000;
        $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] snap;
        logic        saw;
        int          lat;
        rst = 1'b1;
        flush = 1'b0;
        bus.out_ready = 1'b1;
        set_op(4'd0, 0, 0);
        bus.in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        @(negedge clk);
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_in_ready", bus.in_ready, 1);
        chk("rst_out_regs", {bus.out_result, bus.out_branch_addr}, 0);
        chk("rst_out_ctrl", {bus.out_rd, bus.out_reg_write, bus.out_branch}, 0);
        @(posedge clk); #1;

        set_op(4'd0, 5, 7);
        issue();
        @(negedge clk);
        chk("add_out_valid", bus.out_valid, 1);
        chk("add_result", bus.out_result, 12);
        chk("add_mem_addr", bus.out_mem_addr, 12);
        @(posedge clk); #1;

        set_op(4'd1, 3, 4, 32'h20, 32'h100, 0, 0, 1, 1);
        issue();
        @(negedge clk);
        chk("bc_taken", bus.out_branch, 1);
        chk("bc_target", bus.out_branch_addr, 32'h120);
        @(posedge clk); #1;
        set_op(4'd1, 3, 3, 32'h20, 32'h100, 0, 0, 1, 1);
        issue();
        @(negedge clk);
        chk("bc_not_taken", bus.out_branch, 0);
        @(posedge clk); #1;

        set_op(4'd0, 0, 32'h55, 8, 32'h40, 1, 1, 0, 1);
        issue();
        @(negedge clk);
        chk("buc_target", bus.out_branch_addr, 32'h48);
        chk("buc_link", bus.out_result, 32'h44);
        @(posedge clk); #1;
        drain();

        stream(4'd4, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 0, 0);
        stream(4'd5, 32'd1, 32'd31, 0, 0);
        stream(4'd5, 32'd3, 32'd0, 32'd33, 1);
        stream(4'd6, 32'h8000_0000, 32'd4, 0, 0);
        stream(4'd7, 32'h8000_0000, 32'd4, 0, 0);
        stream(4'd8, 32'hFFFF_FFFF, 32'd1, 0, 0);
        stream(4'd9, 32'hFFFF_FFFF, 32'd1, 0, 0);
        stream(4'd1, 32'd0, 32'd1, 0, 0);
        stream(4'd2, 32'hDEAD_BEEF, 32'd0, 32'h0000_FFFF, 1);
        stream(4'd3, 32'h1200_0000, 32'h0000_0034, 0, 0);
        bus.in_valid = 1'b0;
        drain();

        // Backpressure: held output stays put, next op enters as soon as out_ready rises.
        bus.out_ready = 1'b0;
        set_op(4'd0, 32'h1000, 32'h234);
        issue();
        set_op(4'd1, 32'd50, 32'd8);
        @(negedge clk);
        snap = {bus.out_result, bus.out_mem_addr};
        for (int i = 0; i < 3; i++) begin
            if (i != 0) @(negedge clk);
            chk("bp_in_ready", bus.in_ready, 0);
            chk("bp_stable", {bus.out_result, bus.out_mem_addr}, 64'h0000_1234_0000_1234);
            @(posedge clk); #1;
        end
        bus.out_ready = 1'b1;
        @(negedge clk);
        chk("bp_release_in_ready", bus.in_ready, 1);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        @(negedge clk);
        chk("bp_next_result", bus.out_result, 42);
        chk("bp_snapshot", snap, 64'h0000_1234_0000_1234);
        @(posedge clk); #1;
        drain();

`ifdef EXEC_MULDIV_EN
        md_run(4'd12, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, "div_ovf", lat);
        md_run(4'd13, 32'd7, 32'd0, 32'hFFFF_FFFF, "divu_zero", lat);
        md_run(4'd15, 32'd7, 32'd0, 32'd7, "remu_zero", lat);
        md_run(4'd14, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, "rem_neg", lat);
        md_run(4'd11, 32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFFF, "mulh_neg", lat);
        md_run(4'd10, 32'd6, 32'd7, 32'd42, "mul", lat);
        chk("mul_latency", lat, 33);
        drain();

        set_op(4'd13, 32'd100, 32'd7);
        issue();
        @(posedge clk); #1;
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        @(negedge clk);
        chk("mdflush_in_ready", bus.in_ready, 1);
        chk("mdflush_out_valid", bus.out_valid, 0);
        saw = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            saw = saw | bus.out_valid;
        end
        chk("mdflush_no_output", saw, 0);
        @(posedge clk); #1;
        set_op(4'd0, 32'd20, 32'd22);
        issue();
        @(negedge clk);
        chk("mdflush_add_after", bus.out_result, 42);
        @(posedge clk); #1;
        drain();
`else
        set_op(4'd12, 32'd100, 32'd7);
        issue();
        @(negedge clk);
        chk("nomd_valid", bus.out_valid, 1);
        chk("nomd_result", bus.out_result, 0);
        @(posedge clk); #1;
        drain();
`endif

        // Flush discards a held result and blocks the instruction presented alongside it.
        bus.out_ready = 1'b0;
        set_op(4'd0, 32'd1, 32'd2);
        issue();
        set_op(4'd1, 32'd9, 32'd4);
        flush = 1'b1;
        @(negedge clk);
        chk("flush_held_in_ready", bus.in_ready, 0);
        @(posedge clk); #1;
        flush = 1'b0;
        bus.in_valid = 1'b0;
        @(negedge clk);
        chk("flush_out_valid", bus.out_valid, 0);
        chk("flush_in_ready_after", bus.in_ready, 1);
        @(posedge clk); #1;
        bus.out_ready = 1'b1;

        set_op(4'd0, 32'd30, 32'd3);
        flush = 1'b1;
        @(negedge clk);
        chk("flush_idle_in_ready", bus.in_ready, 0);
        @(posedge clk); #1;
        flush = 1'b0;
        issue();
        @(negedge clk);
        chk("flush_then_add", bus.out_result, 33);
        @(posedge clk); #1;
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
